cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Run-control and program-memory owner for the 4-bit toy CPU. It holds the 16x8 program/data memory, lets a host load words while the CPU is frozen, and sequences the core via cpu_rst and cpu_hold (wired to the core's scan_en), giving IDLE/RUN/STEP/HALT control with a cycle budget. It sits between the top-level host pins and the cpu instance.

Parameters:
CNT_W, 16, width of the executed-cycle counter (saturating).
MEM_DEPTH, 16, program memory words; fixed by the 4-bit address, not to be overridden.

Ports:
clk  in  1  system clock; the CPU core shares it.
rst  in  1  synchronous active-high reset.
host_cmd_valid  in  1  host command valid.
host_cmd_ready  out  1  command accepted when valid&ready at posedge.
host_cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 HALT.
host_addr  in  4  LOAD target address.
host_data  in  8  LOAD word, or RUN cycle budget (0 = unlimited).
cpu_rst  out  1  to core rst.
cpu_hold  out  1  to core scan_en; 1 freezes the core.
cpu_addr  in  4  core addr.
cpu_we  in  1  core we.
cpu_wdata  in  8  core data_out.
cpu_rdata  out  8  core data_in; combinational mem[cpu_addr].
state_o  out  2  current state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
cycle_count  out  CNT_W  number of unheld cycles since leaving IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cpu_rst=1, cpu_hold=1, cycle_count=0, budget=0, all memory words cleared to 8'h00 (NOP).
- Outputs are registered except cpu_rdata and host_cmd_ready.
- IDLE: cpu_rst=1, cpu_hold=1.
- HALT: cpu_rst=0, cpu_hold=1. Core state is frozen and readable through the scan chain.
- RUN and STEP: cpu_rst=0, cpu_hold=0.
- host_cmd_ready:
  - 1 in IDLE and HALT.
  - In RUN, 1 only when host_cmd==HALT.
  - 0 in STEP.
  - The host keeps valid and its fields stable until ready.
- LOAD (IDLE or HALT): mem[host_addr] <= host_data at the accepting posedge. State does not change. The word is visible on cpu_rdata the next cycle.
- RUN accepted:
  - Budget is latched from host_data; state becomes RUN next cycle.
  - From IDLE, cycle_count is cleared in the same edge.
  - From HALT, cycle_count continues.
- STEP accepted: state becomes STEP for exactly one cycle, then HALT. cycle_count increments by 1. A STEP from IDLE also clears cycle_count first.
- HALT command:
  - In RUN: next state HALT.
  - In HALT: next state IDLE, which re-asserts cpu_rst so the PC returns to 0 on the core's next falling edge.
  - In IDLE: no-op.
- Budget: while RUN with budget N≠0, the block goes to HALT after exactly N cycles with cpu_hold=0 (cycle_count advances by N). N=0 runs until a HALT command. A host HALT and budget expiry in the same cycle give HALT.
- cycle_count:
  - Increments on every posedge at which cpu_hold=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only on rst or on leaving IDLE.
- Memory write by the core: mem[cpu_addr] <= cpu_wdata on the falling edge of clk when cpu_we=1 and cpu_hold=0. At that edge the core drives its operand address. The host never writes in RUN/STEP, so there is no port conflict.
- Undefined host_cmd cannot occur (2-bit full decode). Commands issued in the wrong state are not accepted (ready=0), not dropped.
- rst mid-RUN: the sequencer returns to IDLE and clears memory. A program must be reloaded.

Decomposition:
- Package cpu_seq_pkg holds:
  - state encodings IDLE/RUN/STEP/HALT;
  - command codes CMD_LOAD/CMD_RUN/CMD_STEP/CMD_HALT;
  - MEM_DEPTH and word width 8.
- Sub-module prog_mem holds the 16x8 array: synchronous clear on rst, host write port on posedge, core write port on negedge, combinational read on cpu_addr. The FSM, budget counter and cycle counter stay in cpu_sequencer.

Test Plan:
- After rst: state_o=00, cpu_rst=1, cpu_hold=1, cycle_count=0, cpu_rdata=8'h00 for cpu_addr 0..15.
- LOAD addr 3 data 8'hA1 in IDLE -> ready=1; next cycle with cpu_addr=3, cpu_rdata=8'hA1; state_o stays 00.
- RUN with host_data=5 from IDLE -> cpu_rst=0 and cpu_hold=0 for exactly 5 cycles, then state_o=11, cpu_hold=1, cycle_count=5.
- From HALT, STEP three times -> each gives one cycle with cpu_hold=0 and ready=0; cycle_count 5→8; state_o returns to 11 after each.
- RUN with host_data=0, then HALT after 20 cycles -> halts on the accepting edge; cycle_count=20. During RUN, LOAD has ready=0 and memory is unchanged. A second HALT -> state_o=00, cpu_rst=1.
- Core write: cpu_we=1, cpu_addr=7, cpu_wdata=8'h5C while running -> mem[7]=8'h5C after the falling edge. The same stimulus with cpu_hold=1 leaves mem[7] unchanged.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings and sizes for the toy-CPU sequencer and its program memory.
package cpu_seq_pkg;

   localparam int unsigned MEM_DEPTH = 16;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned WORD_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10,
      HALT = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      CMD_LOAD = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_STEP = 2'b10,
      CMD_HALT = 2'b11
   } cmd_e;

endpackage

// File: rtl/prog_mem.sv
// 16x8 program/data memory: host write on posedge, core write captured on negedge,
// combinational read for the core.
module prog_mem
   import cpu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [WORD_W-1:0] host_wdata_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [WORD_W-1:0] core_wdata_i,
   output logic [WORD_W-1:0] core_rdata_o
);

   logic [WORD_W-1:0] mem_q [MEM_DEPTH];
   logic              pend_tog_q;
   logic              done_tog_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [WORD_W-1:0] pend_data_q;
   logic              pend_v;

   // The array has a single (posedge) writer: a core write is latched on the falling
   // edge, forwarded to the read port at once, and folded into the array next posedge.
   always_ff @(negedge clk) begin
      if (rst) begin
         pend_tog_q <= done_tog_q;
      end else if (core_we_i) begin
         pend_tog_q  <= ~pend_tog_q;
         pend_addr_q <= core_addr_i;
         pend_data_q <= core_wdata_i;
      end
   end

   assign pend_v = pend_tog_q ^ done_tog_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i[ADDR_W-1:0]] <= '0;
         end
         done_tog_q <= pend_tog_q;
      end else begin
         if (pend_v) begin
            mem_q[pend_addr_q] <= pend_data_q;
            done_tog_q         <= pend_tog_q;
         end
         if (host_we_i) begin
            mem_q[host_addr_i] <= host_wdata_i;
         end
      end
   end

   assign core_rdata_o = (pend_v && (pend_addr_q == core_addr_i)) ? pend_data_q
                                                                  : mem_q[core_addr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Run control for the 4-bit toy CPU: IDLE/RUN/STEP/HALT sequencing with a cycle budget,
// a saturating executed-cycle counter and ownership of the program memory.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_cmd_valid,
   output logic                host_cmd_ready,
   input  logic [1:0]          host_cmd,
   input  logic [ADDR_W-1:0]   host_addr,
   input  logic [WORD_W-1:0]   host_data,
   output logic                cpu_rst,
   output logic                cpu_hold,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic                cpu_we,
   input  logic [WORD_W-1:0]   cpu_wdata,
   output logic [WORD_W-1:0]   cpu_rdata,
   output logic [1:0]          state_o,
   output logic [CNT_W-1:0]    cycle_count
);

   state_e            state_q, state_d;
   logic              rst_q;
   logic              hold_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] budget_q, budget_d;
   logic [WORD_W-1:0] rem_q, rem_d;
   logic              clr_cnt;
   logic              accept;
   cmd_e              cmd;

   assign cmd = cmd_e'(host_cmd);

   always_comb begin
      host_cmd_ready = 1'b0;
      unique case (state_q)
         IDLE, HALT: host_cmd_ready = 1'b1;
         RUN:        host_cmd_ready = (cmd == CMD_HALT);
         default:    host_cmd_ready = 1'b0;
      endcase
   end

   assign accept = host_cmd_valid & host_cmd_ready;

   always_comb begin
      state_d  = state_q;
      budget_d = budget_q;
      rem_d    = rem_q;
      clr_cnt  = 1'b0;
      unique case (state_q)
         IDLE, HALT: begin
            if (accept) begin
               unique case (cmd)
                  CMD_RUN: begin
                     state_d  = RUN;
                     budget_d = host_data;
                     rem_d    = host_data;
                     clr_cnt  = (state_q == IDLE);
                  end
                  CMD_STEP: begin
                     state_d = STEP;
                     clr_cnt = (state_q == IDLE);
                  end
                  CMD_HALT: begin
                     if (state_q == HALT) state_d = IDLE;
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Host halt and budget expiry land on the same edge: both mean HALT.
            if (accept || ((budget_q != '0) && (rem_q == 8'd1))) begin
               state_d = HALT;
            end else if (budget_q != '0) begin
               rem_d = rem_q - 8'd1;
            end
         end
         STEP: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (!hold_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rst_q    <= 1'b1;
         hold_q   <= 1'b1;
         cnt_q    <= '0;
         budget_q <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         rst_q    <= (state_d == IDLE);
         hold_q   <= (state_d == IDLE) || (state_d == HALT);
         cnt_q    <= cnt_d;
         budget_q <= budget_d;
         rem_q    <= rem_d;
      end
   end

   assign cpu_rst     = rst_q;
   assign cpu_hold    = hold_q;
   assign state_o     = state_q;
   assign cycle_count = cnt_q;

   prog_mem u_prog_mem (
      .clk          (clk),
      .rst          (rst),
      .host_we_i    (accept && (cmd == CMD_LOAD)),
      .host_addr_i  (host_addr),
      .host_wdata_i (host_data),
      .core_we_i    (cpu_we && !hold_q),
      .core_addr_i  (cpu_addr),
      .core_wdata_i (cpu_wdata),
      .core_rdata_o (cpu_rdata)
   );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized command sequences scored
// against a transaction-level model of state, cycle count and memory contents.
module tb_cpu_sequencer;

   localparam int unsigned CW   = 6;
   localparam int unsigned CMAX = (1 << CW) - 1;

   localparam logic [1:0] C_LOAD = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_HALT = 2'd3;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;

   logic          clk = 1'b0;
   logic          rst;
   logic          host_cmd_valid;
   logic          host_cmd_ready;
   logic [1:0]    host_cmd;
   logic [3:0]    host_addr;
   logic [7:0]    host_data;
   logic          cpu_rst;
   logic          cpu_hold;
   logic [3:0]    cpu_addr;
   logic          cpu_we;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic [1:0]    state_o;
   logic [CW-1:0] cycle_count;

   cpu_sequencer #(.CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd_ready (host_cmd_ready),
      .host_cmd       (host_cmd),
      .host_addr      (host_addr),
      .host_data      (host_data),
      .cpu_rst        (cpu_rst),
      .cpu_hold       (cpu_hold),
      .cpu_addr       (cpu_addr),
      .cpu_we         (cpu_we),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .state_o        (state_o),
      .cycle_count    (cycle_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned hl_cnt   = 0;

   logic [1:0]  m_state;
   int unsigned m_cnt;
   logic [7:0]  m_mem [16];

   // Edges at which the core was released.
   always @(posedge clk) if (!rst && cpu_hold == 1'b0) hl_cnt <= hl_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned sat(input int unsigned v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present a command until accepted; returns 1 time unit after the accepting edge.
   task automatic issue(input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      host_cmd_valid = 1'b1;
      host_cmd  = c;
      host_addr = a;
      host_data = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         #2;
         if (host_cmd_ready) ok = 1'b1;
         sync();
      end
      host_cmd_valid = 1'b0;
      chk("accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic check_mem_all(input string tag);
      for (int a = 0; a < 16; a++) begin
         cpu_addr = 4'(a);
         #1;
         chk(tag, {24'd0, cpu_rdata}, {24'd0, m_mem[a]});
      end
   endtask

   task automatic do_load(input logic [3:0] a, input logic [7:0] d);
      issue(C_LOAD, a, d);
      m_mem[a] = d;
      cpu_addr = a;
      #1;
      chk("load_rdata", {24'd0, cpu_rdata}, {24'd0, d});
      chk("load_state", {30'd0, state_o}, {30'd0, m_state});
      sync();
   endtask

   task automatic do_step(input bit core_wr);
      int unsigned base;
      if (m_state == S_IDLE) m_cnt = 0;
      base = hl_cnt;
      issue(C_STEP, 4'd0, 8'd0);
      chk("step_state", {30'd0, state_o}, {30'd0, S_STEP});
      chk("step_hold",  {31'd0, cpu_hold}, 32'd0);
      chk("step_rst",   {31'd0, cpu_rst},  32'd0);
      chk("step_ready", {31'd0, host_cmd_ready}, 32'd0);
      if (core_wr) begin
         cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'h5C;
         #5;
         chk("core_wr_run", {24'd0, cpu_rdata}, 32'h5C);
         cpu_we = 1'b0;
         m_mem[7] = 8'h5C;
      end
      sync();
      m_cnt = sat(m_cnt + 1);
      m_state = S_HALT;
      chk("step_after_state", {30'd0, state_o}, {30'd0, S_HALT});
      chk("step_after_hold",  {31'd0, cpu_hold}, 32'd1);
      chk("step_count",       {26'd0, cycle_count}, m_cnt);
      chk("step_cycles",      hl_cnt - base, 32'd1);
      if (core_wr) begin
         cpu_addr = 4'd7;
         chk("core_wr_commit", {24'd0, cpu_rdata}, 32'h5C);
         cpu_we = 1'b1; cpu_wdata = 8'h33;
         #5;
         chk("core_wr_held", {24'd0, cpu_rdata}, 32'h5C);
         cpu_we = 1'b0;
         sync();
      end
   endtask

   // n = budget (0 = unlimited); k != 0 means a host HALT lands on the k-th run edge.
   task automatic do_run(input logic [7:0] n, input int unsigned k, input bit probe);
      int unsigned base, expc;
      if (m_state == S_IDLE) m_cnt = 0;
      base = hl_cnt;
      issue(C_RUN, 4'd0, n);
      chk("run_state", {30'd0, state_o}, {30'd0, S_RUN});
      chk("run_hold",  {31'd0, cpu_hold}, 32'd0);
      chk("run_rst",   {31'd0, cpu_rst},  32'd0);
      if (k != 0) begin
         for (int unsigned i = 1; i < k; i++) begin
            if (probe && i == 1) begin
               host_cmd_valid = 1'b1; host_cmd = C_LOAD; host_addr = 4'd3; host_data = 8'hFF;
               #2;
               chk("load_in_run_ready", {31'd0, host_cmd_ready}, 32'd0);
            end
            sync();
            host_cmd_valid = 1'b0;
         end
         issue(C_HALT, 4'd0, 8'd0);
         expc = k;
      end else begin
         for (int i = 0; i < 600 && cpu_hold == 1'b0; i++) sync();
         expc = n;
      end
      m_cnt = sat(m_cnt + expc);
      m_state = S_HALT;
      chk("run_end_state", {30'd0, state_o}, {30'd0, S_HALT});
      chk("run_end_hold",  {31'd0, cpu_hold}, 32'd1);
      chk("run_cycles",    hl_cnt - base, expc);
      chk("run_count",     {26'd0, cycle_count}, m_cnt);
      sync();
   endtask

   task automatic do_halt();
      issue(C_HALT, 4'd0, 8'd0);
      m_state = S_IDLE;
      chk("halt_state", {30'd0, state_o}, {30'd0, S_IDLE});
      chk("halt_rst",   {31'd0, cpu_rst},  32'd1);
      chk("halt_hold",  {31'd0, cpu_hold}, 32'd1);
      chk("halt_count", {26'd0, cycle_count}, m_cnt);
      sync();
   endtask

   initial begin
      logic [7:0]  n;
      int unsigned k;
      rst = 1'b1; host_cmd_valid = 1'b0; host_cmd = C_LOAD; host_addr = '0; host_data = '0;
      cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
      for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
      m_state = S_IDLE;
      m_cnt = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_state", {30'd0, state_o}, {30'd0, S_IDLE});
      chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_count", {26'd0, cycle_count}, 32'd0);
      check_mem_all("rst_mem");
      sync();

      chk("idle_ready", {31'd0, host_cmd_ready}, 32'd1);
      do_load(4'd3, 8'hA1);
      do_run(8'd5, 0, 1'b0);
      for (int s = 0; s < 3; s++) do_step(1'b0);
      do_step(1'b1);
      do_halt();
      do_run(8'd0, 20, 1'b1);
      cpu_addr = 4'd3;
      #1 chk("mem_after_run_load", {24'd0, cpu_rdata}, {24'd0, m_mem[3]});
      do_halt();
      do_run(8'd0, 70, 1'b0);
      do_halt();
      do_run(8'd4, 4, 1'b0);
      do_halt();
      do_halt();

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: do_load(4'($urandom_range(0, 15)), 8'($urandom));
            1: begin
               n = 8'($urandom_range(0, 12));
               if (n == 0) k = $urandom_range(1, 15);
               else k = ($urandom_range(0, 1) != 0) ? $urandom_range(1, n) : 0;
               do_run(n, k, 1'b0);
            end
            2: do_step(1'b0);
            default: do_halt();
         endcase
      end
      check_mem_all("final_mem");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
